// File: rtl/mux41_rr_arbiter_if.sv
// Shared-mux arbiter bus: four requester data/request lines, per-source acks,
// grant/select status and the single valid/ready output stage.
interface mux41_rr_arbiter_if #(
  parameter int W = 8
);
  logic [3:0]   req;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [3:0]   ack;
  logic [3:0]   gnt;
  logic         s0;
  logic         s1;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;
  logic         busy;

  modport master (
    input  req, d0, d1, d2, d3, y_ready,
    output ack, gnt, s0, s1, y, y_valid, busy
  );

  modport slave (
    output req, d0, d1, d2, d3, y_ready,
    input  ack, gnt, s0, s1, y, y_valid, busy
  );
endinterface

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: grants bounded bursts from one
// requester at a time into a registered valid/ready output stage.
module mux41_rr_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux41_rr_arbiter_if.master   bus
);
  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  state_t       state;
  logic [1:0]   ptr;
  logic [3:0]   gnt;
  logic         s0;
  logic         s1;
  logic [3:0]   beat;
  logic [W-1:0] y;
  logic         y_valid;

  logic [1:0]   g;
  logic [1:0]   cand;
  logic [1:0]   sel_idx;
  logic         sel_found;
  logic         take;
  logic [W-1:0] src_d;
  logic [3:0]   ack;

  // The registered selects double as the grantee index during XFER.
  assign g = {s0, s1};

  // Scan offsets ptr+4 down to ptr+1; later hits overwrite, so ptr+1 wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr - 2'(k);
      if (bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    src_d = '0;
    case (g)
      2'd0: src_d = bus.d0;
      2'd1: src_d = bus.d1;
      2'd2: src_d = bus.d2;
      2'd3: src_d = bus.d3;
      default: src_d = '0;
    endcase
  end

  assign take = (state == XFER) && bus.req[g] && (!y_valid || bus.y_ready)
                && (beat < BURST_LAST);
  assign ack  = take ? (4'b0001 << g) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      gnt     <= '0;
      s0      <= 1'b0;
      s1      <= 1'b0;
      beat    <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      // Output register runs regardless of state so the last word drains in IDLE.
      if (take) begin
        y       <= src_d;
        y_valid <= 1'b1;
      end else if (y_valid && bus.y_ready) begin
        y_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sel_found) begin
            state    <= XFER;
            gnt      <= 4'b0001 << sel_idx;
            {s0, s1} <= sel_idx;
            beat     <= '0;
          end
        end
        XFER: begin
          if (take) beat <= beat + 4'd1;
          if (!bus.req[g] || (take && (beat + 4'd1 == BURST_LAST))) begin
            state <= IDLE;
            ptr   <= g;
            gnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack     = ack;
  assign bus.gnt     = gnt;
  assign bus.s0      = s0;
  assign bus.s1      = s1;
  assign bus.y       = y;
  assign bus.y_valid = y_valid;
  assign bus.busy    = (state == XFER);
endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: reset, round-robin order, early end,
// backpressure, single-requester re-grant and mid-burst reset.
module tb_mux41_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux41_rr_arbiter_if #(.W(8)) bus ();

  mux41_rr_arbiter #(.W(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entered at the negedge of the first XFER cycle of grantee g; leaves at the
  // negedge following the single IDLE cycle that ends the burst.
  task automatic full_burst(input int g);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    check("burst_gnt", 32'(bus.gnt), 32'(oh));
    check("burst_sel", 32'({bus.s0, bus.s1}), 32'(g));
    check("burst_busy", 32'(bus.busy), 32'd1);
    for (int b = 0; b < 4; b++) begin
      check("burst_ack", 32'(bus.ack), 32'(oh));
      @(negedge clk);
      check("burst_y", 32'(bus.y), 32'(8'hA0 + g));
      check("burst_yv", 32'(bus.y_valid), 32'd1);
    end
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bus.req = 4'b1111;
    bus.y_ready = 1'b1;
    bus.d0 = 8'hA0;
    bus.d1 = 8'hA1;
    bus.d2 = 8'hA2;
    bus.d3 = 8'hA3;

    // 1. reset state with all requests pending
    #2;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_yv", 32'(bus.y_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_sel", 32'({bus.s0, bus.s1}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_gnt", 32'(bus.gnt), 32'b0001);

    // 2. round-robin order 0,1,2,3,0
    full_burst(0);
    full_burst(1);
    full_burst(2);
    full_burst(3);
    full_burst(0);

    // 3. early end: req2 alone for two beats, then req3 and req0
    do_reset();
    bus.req = 4'b0100;
    @(negedge clk);
    check("early_gnt", 32'(bus.gnt), 32'b0100);
    check("early_ack0", 32'(bus.ack), 32'b0100);
    @(negedge clk);
    check("early_ack1", 32'(bus.ack), 32'b0100);
    @(negedge clk);
    bus.req = 4'b1001;
    #1;
    check("early_ack_drop", 32'(bus.ack), 32'd0);
    @(negedge clk);
    check("early_idle_gnt", 32'(bus.gnt), 32'd0);
    check("early_idle_busy", 32'(bus.busy), 32'd0);
    check("early_y", 32'(bus.y), 32'hA2);
    @(negedge clk);
    check("early_next_gnt", 32'(bus.gnt), 32'b1000);
    check("early_next_sel", 32'({bus.s0, bus.s1}), 32'd3);

    // 4. backpressure: three stalled cycles in mid-burst, distinct words per beat
    do_reset();
    bus.req = 4'b0001;
    bus.d0 = 8'h10;
    @(negedge clk);
    check("bp_ack0", 32'(bus.ack), 32'b0001);
    @(negedge clk);
    check("bp_y0", 32'(bus.y), 32'h10);
    bus.d0 = 8'h11;
    bus.y_ready = 1'b0;
    #1;
    check("bp_stall_ack", 32'(bus.ack), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_stall_y", 32'(bus.y), 32'h10);
      check("bp_stall_yv", 32'(bus.y_valid), 32'd1);
      check("bp_stall_ack2", 32'(bus.ack), 32'd0);
    end
    @(negedge clk);
    bus.y_ready = 1'b1;
    #1;
    check("bp_resume_ack", 32'(bus.ack), 32'b0001);
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      check("bp_y", 32'(bus.y), 32'(8'h10 + b));
      bus.d0 = 8'(8'h10 + b + 1);
      if (b < 3) check("bp_ack", 32'(bus.ack), 32'b0001);
    end
    check("bp_end_gnt", 32'(bus.gnt), 32'd0);
    check("bp_end_busy", 32'(bus.busy), 32'd0);

    // 5. single requester re-granted with one IDLE cycle between bursts
    do_reset();
    bus.d0 = 8'hA0;
    bus.req = 4'b0010;
    @(negedge clk);
    full_burst(1);
    full_burst(1);
    full_burst(1);

    // 6. reset during beat 2 of a grant to req3
    do_reset();
    bus.req = 4'b1000;
    @(negedge clk);
    check("mr_gnt", 32'(bus.gnt), 32'b1000);
    check("mr_ack0", 32'(bus.ack), 32'b1000);
    @(negedge clk);
    check("mr_ack1", 32'(bus.ack), 32'b1000);
    rst_n = 1'b0;
    #1;
    check("mr_yv", 32'(bus.y_valid), 32'd0);
    check("mr_gnt0", 32'(bus.gnt), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_y", 32'(bus.y), 32'd0);
    check("mr_ack", 32'(bus.ack), 32'd0);
    bus.req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_next_gnt", 32'(bus.gnt), 32'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux41_rr_arbiter.md
# mux41_rr_arbiter

Round-robin controller that shares one 4:1 data mux among four requesters and feeds a single registered output stage with a valid/ready handshake. It arbitrates between requests, drives the mux selects `s0`/`s1`, and moves bounded bursts of data words from the granted source to the output register. It sits between the four data producers and the one downstream consumer of the shared path.

## Interface

**Parameters**
- `W`, default 8: data width of `d0..d3` and `y`.
- `MAX_BURST`, default 4: maximum beats per grant. Legal range is 1..15.

**Ports**
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `req`, input, 4: `req[i]` means requester i has a valid word on `d<i>`.
- `d0`, `d1`, `d2`, `d3`, input, W each: requester data.
- `ack`, output, 4: combinational, one-hot or zero. `ack[i]` means `d<i>` is consumed this cycle.
- `gnt`, output, 4: registered, one-hot or zero. It is the current grant.
- `s0`, `s1`, output, 1 each: registered mux selects. The source index is {s0,s1}, with `s0` as the MSB:
  - d0: s0=0, s1=0
  - d1: s0=0, s1=1
  - d2: s0=1, s1=0
  - d3: s0=1, s1=1
- `y`, output, W: registered output word.
- `y_valid`, output, 1: `y` holds a word not yet taken downstream.
- `y_ready`, input, 1: the downstream consumer accepts `y` when `y_valid && y_ready`.
- `busy`, output, 1: high in the XFER state.

## Operation

**Reset values** (asynchronous, take effect immediately on `rst_n` low):
- state = IDLE, `ptr` = 3, `gnt` = 0, `s0` = `s1` = 0.
- `y` = 0, `y_valid` = 0, beat count = 0, `busy` = 0.
- `ack` = 0, because it is derived from state.

**State machine**
- **IDLE:**
  - `gnt` = 0.
  - If `req` is nonzero, select the first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next cycle: state = XFER, `gnt` = one-hot of the selected index, {s0,s1} = index, beat count = 0.
  - If `req` = 0, stay in IDLE.
- **XFER** (grantee g):
  - `ack[g]` = `req[g]` && (!`y_valid` || `y_ready`) && beat count < MAX_BURST.
  - On `ack[g]`: `y` <= `d<g>`, `y_valid` <= 1, beat count += 1.
  - Leave for IDLE when `req[g]` = 0, or when the beat count reaches MAX_BURST after a beat. If both happen in the same cycle, the result is the same.
  - On leaving: `ptr` <= g, `gnt` <= 0. {s0,s1} keep their last value.
- **Output register:**
  - `y_valid` clears when `y_valid && y_ready && !ack`.
  - It stays 1 on a simultaneous drain and refill.
  - This logic is independent of the state, so the last word of a burst drains while the block is in IDLE.

**Other rules**
- Requests from non-granted requesters are ignored and their `ack` stays 0.
- Only one requester is ever acked per cycle.
- Beat counter width is 4 bits; the count never exceeds MAX_BURST.

## Timing

- **Request to grant:** `req[i]` seen in IDLE at edge N gives `gnt`/`s0`/`s1` valid after edge N+1.
- **First transfer:** `ack[i]` can be high in cycle N+1. `y_valid` = 1 with the first word after edge N+2, so the minimum request-to-output latency is 2 cycles.
- **Sustained rate:** one beat per cycle while `y_ready` = 1.
- **Between grants:** exactly one IDLE cycle, including when the same requester is re-granted.
- **Stall:** with `y_valid` = 1 and `y_ready` = 0, `ack` is 0 and the beat count and `y` hold.
- **Reset mid-burst:** all state clears asynchronously, any pending `y` is discarded, and the first grant after reset goes to req0 if it is asserted.

## Test plan

1. **Reset state.** Assert `rst_n` = 0 with `req` = 4'b1111. Required: `gnt` = 0, `ack` = 0, `y_valid` = 0, `y` = 0, `s0` = `s1` = 0. After release, the first grant is `gnt` = 4'b0001 one cycle later.
2. **Round-robin order.** All four requests held, `y_ready` = 1, MAX_BURST = 4, and `d<i>` = 8'hA0 + i. Required:
   - Grant order 0, 1, 2, 3, 0.
   - Each grant gives 4 consecutive `ack`s and 4 `y` words.
   - {s0,s1} = 00, 01, 10, 11.
   - One idle cycle between grants.
3. **Early end.** req2 alone drops `req` after 2 beats. Required: exactly 2 beats, then IDLE, then `ptr` = 2. If req3 and req0 then both request, req3 is granted next.
4. **Backpressure.** `y_ready` = 0 for 3 cycles in mid-burst. Required:
   - `ack` = 0 and `y` stable during the stall.
   - The beat count is unchanged.
   - Transfer resumes on the cycle `y_ready` returns to 1, and no word is lost or duplicated.
5. **Single requester re-grant.** Only req1, always asserted. Required: bursts of MAX_BURST beats separated by one IDLE cycle, with `gnt` = 4'b0010 each time.
6. **Reset mid-burst.** Pulse `rst_n` low during beat 2 of a grant to req3. Required: immediate `y_valid` = 0, `gnt` = 0, `busy` = 0. The next grant goes to the lowest-index active requester.
